// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared definitions for the CPU datapath ALU.
//   - SEL field positions (zero-B, invert-B, carry-in, function field)
//   - function codes carried in SEL[1:0]
//   - named full 5-bit opcodes used by the decoder and by callers
package cpu_alu_pkg;

    localparam int SEL_ZERO_B = 4;
    localparam int SEL_INV_B  = 3;
    localparam int SEL_CIN    = 2;
    localparam int SEL_FN_HI  = 1;
    localparam int SEL_FN_LO  = 0;

    typedef enum logic [1:0] {
        FN_ADD   = 2'b00,
        FN_AND   = 2'b01,
        FN_PASSA = 2'b10,
        FN_PASSB = 2'b11
    } fn_e;

    localparam logic [4:0] ADD    = 5'b00000;  // A + B
    localparam logic [4:0] ADDINC = 5'b00100;  // A + B + 1
    localparam logic [4:0] SUB    = 5'b01100;  // A - B
    localparam logic [4:0] SUBDEC = 5'b01000;  // A - B - 1
    localparam logic [4:0] INC    = 5'b10100;  // A + 1
    localparam logic [4:0] DEC    = 5'b11000;  // A - 1
    localparam logic [4:0] AND    = 5'b00001;  // A & B
    localparam logic [4:0] PASSA  = 5'b00010;  // A
    localparam logic [4:0] PASSB  = 5'b00011;  // B

endpackage

// File: rtl/cpu_alu_adder.sv
// cpu_alu_adder: combinational WIDTH-bit adder with carry-in.
//   a, b  : addends (b is already zeroed/inverted by the caller)
//   cin   : carry-in
//   sum   : low WIDTH bits of a + b + cin
//   cout  : raw carry out of the top bit
//   ovf   : signed overflow (addends agree in sign, sum does not)
module cpu_alu_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum  = raw[WIDTH-1:0];
        cout = raw[WIDTH];
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/cpu_alu.sv
// cpu_alu: registered 8-bit ALU (add/sub/inc/dec, AND, pass A/B).
//   clk, rst_n      : clock (rising edge), async active-low reset
//   in_valid, A, B  : operands and function select SEL, sampled when in_valid=1
//   SEL             : [4] zero B, [3] invert B, [2] carry-in, [1:0] function
//   out_valid       : Z/Cout/zero/ovf hold the result of the op one cycle ago
//   Z, Cout, zero, ovf : result, carry/borrow, result-is-zero, signed overflow
// Handshake: in_valid is a one-way qualifier (no ready); every cycle with
// in_valid=1 produces exactly one result with out_valid=1 on the next cycle.
// Idle cycles drop out_valid and leave Z and the flags unchanged.
module cpu_alu
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       SEL,
    output logic             out_valid,
    output logic [WIDTH-1:0] Z,
    output logic             Cout,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH-1:0] ob;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic [WIDTH-1:0] res_z;
    logic             res_cout;
    logic             res_ovf;
    fn_e              fn;

    // Operand conditioning: zero first, then invert, so zero+invert gives all ones.
    always_comb begin
        ob = SEL[SEL_ZERO_B] ? '0 : B;
        if (SEL[SEL_INV_B]) begin
            ob = ~ob;
        end
    end

    cpu_alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (A),
        .b    (ob),
        .cin  (SEL[SEL_CIN]),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    always_comb begin
        fn       = fn_e'(SEL[SEL_FN_HI:SEL_FN_LO]);
        res_z    = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        if (fn == FN_ADD) begin
            res_z    = add_sum;
            // With B inverted the raw carry means "no borrow", so report a borrow.
            res_cout = SEL[SEL_INV_B] ? ~add_cout : add_cout;
            res_ovf  = add_ovf;
        end else if (SEL[SEL_ZERO_B:SEL_CIN] == 3'b000) begin
            case (fn)
                FN_AND:   res_z = A & B;
                FN_PASSA: res_z = A;
                FN_PASSB: res_z = B;
                default:  res_z = '0;
            endcase
        end
        // Remaining codes are undefined and fall through to all-zero results.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Z         <= '0;
            Cout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Z    <= res_z;
                Cout <= res_cout;
                zero <= (res_z == '0);
                ovf  <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_cpu_alu.sv
// tb_cpu_alu: directed-vector bench for cpu_alu with hand-computed expectations.
module tb_cpu_alu;
    import cpu_alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [4:0] SEL;
    logic       out_valid;
    logic [7:0] Z;
    logic       Cout;
    logic       zero;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Expected entries: {out_valid, Z, Cout, zero, ovf}
    logic [11:0] exp_q[$];
    logic [7:0]  held_z;
    logic        held_cout;
    logic        held_zero;
    logic        held_ovf;

    cpu_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .SEL       (SEL),
        .out_valid (out_valid),
        .Z         (Z),
        .Cout      (Cout),
        .zero      (zero),
        .ovf       (ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".Z"},         32'(Z),         32'd0);
        check({tag, ".Cout"},      32'(Cout),      32'd0);
        check({tag, ".zero"},      32'(zero),      32'd0);
        check({tag, ".ovf"},       32'(ovf),       32'd0);
    endtask

    // Scoreboard: pop the oldest expectation and compare every output field.
    task automatic compare_out(input string tag);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".out_valid"}, 32'(out_valid), 32'(e[11]));
            check({tag, ".Z"},         32'(Z),         32'(e[10:3]));
            check({tag, ".Cout"},      32'(Cout),      32'(e[2]));
            check({tag, ".zero"},      32'(zero),      32'(e[1]));
            check({tag, ".ovf"},       32'(ovf),       32'(e[0]));
        end
    endtask

    // Driver: present one operation, expect its result after the next edge.
    task automatic apply(input string tag, input logic [4:0] sel, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ez, input logic ec,
                         input logic ezero, input logic eovf);
        @(negedge clk);
        in_valid = 1'b1;
        SEL      = sel;
        A        = a;
        B        = b;
        exp_q.push_back({1'b1, ez, ec, ezero, eovf});
        held_z    = ez;
        held_cout = ec;
        held_zero = ezero;
        held_ovf  = eovf;
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    // Driver: idle cycle with junk operands; outputs must hold.
    task automatic idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        SEL      = 5'($urandom_range(0, 31));
        A        = 8'($urandom_range(0, 255));
        B        = 8'($urandom_range(0, 255));
        exp_q.push_back({1'b0, held_z, held_cout, held_zero, held_ovf});
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        SEL      = ADD;
        A        = 8'hFF;
        B        = 8'hFF;
        held_z    = 8'h00;
        held_cout = 1'b0;
        held_zero = 1'b0;
        held_ovf  = 1'b0;

        // Reset held with in_valid high: nothing may be captured.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Add / carry
        apply("add_06_08",    ADD,    8'h06, 8'h08, 8'h0E, 1'b0, 1'b0, 1'b0);
        apply("add_ff_08",    ADD,    8'hFF, 8'h08, 8'h07, 1'b1, 1'b0, 1'b0);
        apply("addinc_ff_4b", ADDINC, 8'hFF, 8'h4B, 8'h4B, 1'b1, 1'b0, 1'b0);
        // Logic / pass-through
        apply("and_ff_08",    AND,    8'hFF, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0);
        apply("passa_06",     PASSA,  8'h06, 8'hE1, 8'h06, 1'b0, 1'b0, 1'b0);
        apply("passb_4b",     PASSB,  8'h93, 8'h4B, 8'h4B, 1'b0, 1'b0, 1'b0);
        // Subtract / borrow
        apply("sub_ff_4b",    SUB,    8'hFF, 8'h4B, 8'hB4, 1'b0, 1'b0, 1'b0);
        apply("subdec_ec_06", SUBDEC, 8'hEC, 8'h06, 8'hE5, 1'b0, 1'b0, 1'b0);
        apply("sub_06_ec",    SUB,    8'h06, 8'hEC, 8'h1A, 1'b1, 1'b0, 1'b0);
        apply("subdec_ff_4b", SUBDEC, 8'hFF, 8'h4B, 8'hB3, 1'b0, 1'b0, 1'b0);
        apply("dec_00",       DEC,    8'h00, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b0);
        apply("sub_80_01",    SUB,    8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
        // Increment / wrap / overflow
        apply("inc_06",       INC,    8'h06, 8'hAA, 8'h07, 1'b0, 1'b0, 1'b0);
        apply("inc_ff",       INC,    8'hFF, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b0);
        apply("add_7f_01",    ADD,    8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        // Pass-A via adder codes
        apply("sel10000_00",  5'b10000, 8'h00, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0);
        apply("sel11100_5a",  5'b11100, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0, 1'b0);
        // Undefined codes
        apply("sel11111",     5'b11111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        apply("sel00101",     5'b00101, 8'h3C, 8'hC3, 8'h00, 1'b0, 1'b1, 1'b0);

        // Hold across idle cycles
        apply("hold_src",     ADD,    8'hFF, 8'h08, 8'h07, 1'b1, 1'b0, 1'b0);
        idle("idle_1");
        idle("idle_2");
        apply("hold_src_ovf", ADD,    8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        idle("idle_3");

        // Reset mid-operation: asynchronous clear, pending op discarded.
        apply("pre_reset",    ADD,    8'h06, 8'h08, 8'h0E, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        SEL      = ADD;
        A        = 8'h11;
        B        = 8'h22;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_discard");
        @(negedge clk);
        rst_n = 1'b1;
        held_z    = 8'h00;
        held_cout = 1'b0;
        held_zero = 1'b0;
        held_ovf  = 1'b0;
        apply("post_reset",   ADD,    8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
